nw_flit_injector: RTL and testbench
===================================

Name: nw_flit_injector

Overview:
- Transmit-side source for the network pipeline register.
- Takes a packet descriptor (destination, length) and a stream of payload words, and emits a flit sequence (head/body/tail, or a single headtail flit).
- Drives the downstream register's push/data_in and obeys its ready, so push is never raised while ready is low.
- Sits at each network-interface injection port, ahead of the first router input pipereg.

Parameters:
- DATA_W, 32, payload bits per flit (flit_t.data width).
- DEST_W, 4, output_port / destination field width.
- LEN_W, 4, packet length field width; encodes L-1, so packets are 1..2**LEN_W flits.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- pkt_valid  input  1  descriptor offered.
- pkt_ready  output  1  descriptor accepted when pkt_valid && pkt_ready.
- pkt_dest  input  DEST_W  destination; copied into control.output_port of every flit.
- pkt_len  input  LEN_W  packet length minus one.
- word_valid  input  1  payload word offered.
- word_ready  output  1  payload word consumed when word_valid && word_ready.
- word_data  input  DATA_W  payload word.
- push  output  1  flit write strobe to downstream register.
- data_out  output  flit_t  flit, valid when push=1.
- ready  input  1  downstream register can accept this cycle.
- busy  output  1  packet in progress.
- pkt_count  output  CNT_W  completed packets, wraps modulo 2**CNT_W.

Behaviour:
- Reset: one clock and one synchronous active-low reset (rst_n), as decided. While rst_n=0, at each clk edge: state<=IDLE, remaining<=0, first<=0, pkt_count<=0. pkt_ready, word_ready and push are forced 0 combinationally while rst_n=0.
- Reset mid-packet: the partial packet is abandoned with no tail flit generated. Downstream recovery is out of scope.
- IDLE state:
  - pkt_ready=1, word_ready=0, push=0, busy=0.
  - Accept: dest_r<=pkt_dest, remaining<=pkt_len, first<=1, go to SEND.
- SEND state:
  - busy=1.
  - word_ready = ready.
  - push = word_valid && ready (combinational).
  - data_out.data = word_data.
  - data_out.control.output_port = dest_r.
  - flit_type: first && remaining==0 gives HEADTAIL; first gives HEAD; remaining==0 gives TAIL; otherwise BODY.
- On push in SEND: first<=0, remaining<=remaining-1. If remaining==0 the packet completes: pkt_count increments.
- Back-to-back packets:
  - pkt_ready is also 1 in SEND in the cycle the last flit is pushed.
  - If pkt_valid is high in that cycle, the new descriptor is latched (first<=1, remaining<=pkt_len) and the state stays SEND.
  - Zero bubble between packets.
- Otherwise, a completed packet returns the block to IDLE.
- Latency: a word presented in SEND with ready=1 is pushed in the same cycle, with zero added cycles. A descriptor takes 1 cycle (IDLE to SEND) before the first flit.
- Stall rules:
  - ready=0 or word_valid=0 means push=0 and all state holds.
  - data_out is don't-care when push=0.
- Invariant, asserted in simulation: push implies ready.
- pkt_len=2**LEN_W-1 gives a maximum packet of 16 flits. remaining never underflows, because it is reloaded or the block leaves SEND at 0.
- pkt_count wraps from 2**CNT_W-1 to 0.
- pkt_valid is ignored in SEND except in the last-flit cycle.
- word_valid is ignored in IDLE.

Decomposition:
- Shared network package holds:
  - flit_t = {control, data};
  - control_t = {flit_type, output_port};
  - the flit_type_t enum HEAD=2'b01, BODY=2'b00, TAIL=2'b10, HEADTAIL=2'b11;
  - DATA_W/DEST_W defaults.
- No sub-module. The FSM plus down-counter lives in one module.
- The bench instantiates nw_flit_injector driving the existing pipeline register to exercise the real handshake.

Test Plan:
- Single-flit packet: dest=3, len=0, word 0xA5A5A5A5, ready=1 -> one push, flit_type HEADTAIL, output_port 3, pkt_count 0->1, back to IDLE.
- Four-flit packet with ready toggling 1,0,1,0,...: words 1..4 -> flits HEAD,BODY,BODY,TAIL carrying 1..4. No push when ready=0. Words held until accepted.
- Back-to-back: len=1 dest=2, then len=2 dest=5 offered during the tail cycle -> 5 consecutive pushes, types H,T,H,B,T, dest changes 2->5 with no bubble.
- word_valid gaps: len=3, word_valid low for 3 cycles after the head -> push stays low through the gap, remaining holds, the sequence completes with correct types.
- Reset mid-packet: rst_n=0 after 2 of 8 flits -> next cycle push=0, pkt_ready=0 while low. After release the block is IDLE and the next packet starts with a HEAD flit.
- Counter wrap with CNT_W=2: send 5 single-flit packets -> pkt_count 1,2,3,0,1. push&&!ready never observed across all tests.

Source files
------------

// File: rtl/nw_flit_injector_pkg.sv
// Shared network types: flit layout, flit type encoding and injector state.
package nw_flit_injector_pkg;

    localparam int NW_DATA_W = 32;
    localparam int NW_DEST_W = 4;

    typedef enum logic [1:0] {
        BODY     = 2'b00,
        HEAD     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_type_t             flit_type;
        logic [NW_DEST_W-1:0]   output_port;
    } control_t;

    typedef struct packed {
        control_t               control;
        logic [NW_DATA_W-1:0]   data;
    } flit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } inj_state_t;

    // Flit position in the packet: the first flit is a head, the one with
    // nothing remaining after it is a tail, and a lone flit is both.
    function automatic flit_type_t flit_type_of(input logic is_first, input logic is_last);
        if (is_first && is_last) return HEADTAIL;
        else if (is_first)       return HEAD;
        else if (is_last)        return TAIL;
        else                     return BODY;
    endfunction

endpackage

// File: rtl/nw_flit_injector.sv
// Injection-port flit source: turns a (dest, len) descriptor plus a stream of
// payload words into a head/body/tail flit sequence for the first pipereg.
module nw_flit_injector
    import nw_flit_injector_pkg::*;
#(
    parameter int DATA_W = NW_DATA_W,
    parameter int DEST_W = NW_DEST_W,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [DEST_W-1:0] pkt_dest,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [DATA_W-1:0] word_data,
    output logic              push,
    output flit_t             data_out,
    input  logic              ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_count
);

    inj_state_t        state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              first_q, first_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic              last_flit;

    assign last_flit = (remaining_q == '0);

    // Next-state, handshakes and flit assembly; a tail push may take the next
    // descriptor in the same cycle so consecutive packets leave no bubble.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        dest_d      = dest_q;
        pkt_count_d = pkt_count_q;
        pkt_ready   = 1'b0;
        word_ready  = 1'b0;
        push        = 1'b0;
        busy        = 1'b0;

        data_out                     = '0;
        data_out.data                = word_data;
        data_out.control.output_port = dest_q;
        data_out.control.flit_type   = flit_type_of(first_q, last_flit);

        case (state_q)
            ST_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    dest_d      = pkt_dest;
                    remaining_d = pkt_len;
                    first_d     = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                busy       = 1'b1;
                word_ready = ready;
                push       = word_valid && ready;
                pkt_ready  = push && last_flit;
                if (push) begin
                    first_d     = 1'b0;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_flit) begin
                        pkt_count_d = pkt_count_q + CNT_W'(1);
                        if (pkt_valid) begin
                            dest_d      = pkt_dest;
                            remaining_d = pkt_len;
                            first_d     = 1'b1;
                        end else begin
                            remaining_d = '0;
                            state_d     = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!rst_n) begin
            pkt_ready  = 1'b0;
            word_ready = 1'b0;
            push       = 1'b0;
        end
    end

    // State register; reset abandons any partial packet without a tail.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
            pkt_count_q <= '0;
            dest_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            pkt_count_q <= pkt_count_d;
            dest_q      <= dest_d;
        end
    end

    assign pkt_count = pkt_count_q;

    // The downstream register must never see a write it cannot take.
    a_push_needs_ready: assert property (@(posedge clk) push |-> ready);

endmodule

// File: tb/tb_nw_flit_injector.sv
// Scoreboard bench for nw_flit_injector: stimulus queues expected flits,
// a negedge monitor pops and compares them whenever push is seen.
module tb_nw_flit_injector;
    import nw_flit_injector_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dest;
    logic [3:0]  pkt_len;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        push;
    flit_t       data_out;
    logic        ready;
    logic        busy;
    logic [1:0]  pkt_count;

    int          errors;
    int          checks;
    flit_t       exp_q[$];
    int          model_count;
    bit          count_pending;
    bit          toggle_en;
    int          last_waits;

    nw_flit_injector #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_dest   (pkt_dest),
        .pkt_len    (pkt_len),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .push       (push),
        .data_out   (data_out),
        .ready      (ready),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream readiness: constant 1, or alternating when toggle_en is set.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) ready = ~ready;
            else           ready = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [3:0] dest, input logic [3:0] len,
                                 input logic wv, input logic [31:0] data);
        pkt_valid  = pv;
        pkt_dest   = dest;
        pkt_len    = len;
        word_valid = wv;
        word_data  = data;
    endtask

    // Offer a descriptor and hold it until it is accepted.
    task automatic sendDescriptor(input logic [3:0] dest, input logic [3:0] len);
        bit acc;
        int n;
        pkt_valid = 1'b1;
        pkt_dest  = dest;
        pkt_len   = len;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = pkt_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pkt_valid = 1'b0;
        if (!acc) checkOutput("desc_timeout", 64'd1, 64'd0);
    endtask

    // Offer one payload word, queueing the flit it should become.
    task automatic sendWord(input logic [31:0] data, input flit_type_t ft, input logic [3:0] dest);
        flit_t f;
        bit acc;
        bit acc_pkt;
        int n;
        f.control.flit_type   = ft;
        f.control.output_port = dest;
        f.data                = data;
        exp_q.push_back(f);
        word_valid = 1'b1;
        word_data  = data;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc     = word_valid && word_ready;
            acc_pkt = pkt_valid && pkt_ready;
            @(posedge clk);
            #1;
            if (acc_pkt) pkt_valid = 1'b0;
            if (!acc) n++;
        end
        last_waits = n;
        word_valid = 1'b0;
        if (!acc) checkOutput("word_timeout", 64'd1, 64'd0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every pushed flit against the scoreboard and checks
    // the packet counter on the cycle after each tail.
    initial begin
        flit_t e;
        model_count   = 0;
        count_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_count   = 0;
                count_pending = 1'b0;
            end else begin
                if (count_pending) begin
                    checkOutput("pkt_count", 64'(pkt_count), 64'(model_count % 4));
                    count_pending = 1'b0;
                end
                if (push) begin
                    checkOutput("push_ready", 64'(ready), 64'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_push", 64'(data_out), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("flit", 64'(data_out), 64'(e));
                        if (e.control.flit_type == TAIL || e.control.flit_type == HEADTAIL) begin
                            model_count++;
                            count_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int wrap_exp[5];
        wrap_exp  = '{1, 2, 3, 0, 1};
        errors    = 0;
        checks    = 0;
        toggle_en = 1'b0;
        rst_n     = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0);

        // Reset state.
        @(negedge clk);
        checkOutput("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        checkOutput("rst_push", 64'(push), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_pkt_ready", 64'(pkt_ready), 64'd1);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;

        // Single-flit packet.
        sendDescriptor(4'd3, 4'd0);
        sendWord(32'hA5A5_A5A5, HEADTAIL, 4'd3);
        @(negedge clk);
        checkOutput("single_back_idle", 64'(busy), 64'd0);
        checkOutput("single_count", 64'(pkt_count), 64'd1);
        @(posedge clk);
        #1;

        // Four-flit packet under alternating ready.
        toggle_en = 1'b1;
        sendDescriptor(4'd6, 4'd3);
        sendWord(32'd1, HEAD, 4'd6);
        sendWord(32'd2, BODY, 4'd6);
        sendWord(32'd3, BODY, 4'd6);
        sendWord(32'd4, TAIL, 4'd6);
        toggle_en = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: second descriptor waits for the tail cycle.
        sendDescriptor(4'd2, 4'd1);
        pkt_valid = 1'b1;
        pkt_dest  = 4'd5;
        pkt_len   = 4'd2;
        sendWord(32'h20, HEAD, 4'd2);
        sendWord(32'h21, TAIL, 4'd2);
        checkOutput("b2b_desc_taken", 64'(pkt_valid), 64'd0);
        sendWord(32'h50, HEAD, 4'd5);
        checkOutput("b2b_no_bubble", 64'(last_waits), 64'd0);
        sendWord(32'h51, BODY, 4'd5);
        sendWord(32'h52, TAIL, 4'd5);

        // word_valid gap after the head.
        sendDescriptor(4'd7, 4'd3);
        sendWord(32'h10, HEAD, 4'd7);
        repeat (3) begin
            @(negedge clk);
            checkOutput("gap_push", 64'(push), 64'd0);
            checkOutput("gap_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        sendWord(32'h11, BODY, 4'd7);
        sendWord(32'h12, BODY, 4'd7);
        sendWord(32'h13, TAIL, 4'd7);

        // Reset mid-packet after 2 of 8 flits.
        sendDescriptor(4'd1, 4'd7);
        sendWord(32'h30, HEAD, 4'd1);
        sendWord(32'h31, BODY, 4'd1);
        rst_n      = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'h32;
        @(negedge clk);
        checkOutput("midrst_push", 64'(push), 64'd0);
        checkOutput("midrst_pkt_ready", 64'(pkt_ready), 64'd0);
        checkOutput("midrst_word_ready", 64'(word_ready), 64'd0);
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        checkOutput("post_rst_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        sendDescriptor(4'd9, 4'd1);
        sendWord(32'h40, HEAD, 4'd9);
        sendWord(32'h41, TAIL, 4'd9);

        // Counter wrap with a 2-bit counter.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            sendDescriptor(4'(i), 4'd0);
            sendWord(32'h100 + 32'(i), HEADTAIL, 4'(i));
            @(negedge clk);
            checkOutput("wrap_count", 64'(pkt_count), 64'(wrap_exp[i]));
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
